// File: rtl/wb_sdr_arb_pkg.sv
// Shared definitions for the round-robin Wishbone arbiter in front of sdrc_top:
// FSM state encodings, cycle type ids and a one-hot to index helper.
package wb_sdr_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT   = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Index of the set bit in a one-hot vector of up to eight masters; 0 when empty.
  function automatic logic [2:0] onehot_idx(input logic [7:0] oh);
    logic [2:0] idx_s;
    idx_s = 3'd0;
    for (int i = 0; i < 8; i++) begin
      idx_s = idx_s | (oh[i] ? 3'(i) : 3'd0);
    end
    return idx_s;
  endfunction

endpackage

// File: rtl/wb_sdr_arb_if.sv
// Bus bundle between NM Wishbone masters, the arbiter and the sdrc_top slave port.
// The slave modport is the arbiter's view; the master modport is the surrounding system's.
interface wb_sdr_arb_if #(
  parameter int NM = 4,
  parameter int DW = 32,
  parameter int AW = 30
);
  logic [NM-1:0]        m_cyc_i;
  logic [NM-1:0]        m_stb_i;
  logic [NM-1:0]        m_we_i;
  logic [NM*AW-1:0]     m_addr_i;
  logic [NM*DW-1:0]     m_dat_i;
  logic [NM*DW/8-1:0]   m_sel_i;
  logic [NM*3-1:0]      m_cti_i;
  logic [NM-1:0]        m_ack_o;
  logic [DW-1:0]        m_dat_o;
  logic [NM-1:0]        m_gnt_o;

  logic                 s_cyc_o;
  logic                 s_stb_o;
  logic                 s_we_o;
  logic [AW-1:0]        s_addr_o;
  logic [DW-1:0]        s_dat_o;
  logic [DW/8-1:0]      s_sel_o;
  logic [2:0]           s_cti_o;
  logic                 s_ack_i;
  logic [DW-1:0]        s_dat_i;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_dat_i, m_sel_i, m_cti_i,
    output m_ack_o, m_dat_o, m_gnt_o,
    output s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_dat_o, s_sel_o, s_cti_o,
    input  s_ack_i, s_dat_i
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_dat_i, m_sel_i, m_cti_i,
    input  m_ack_o, m_dat_o, m_gnt_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_dat_o, s_sel_o, s_cti_o,
    output s_ack_i, s_dat_i
  );
endinterface

// File: rtl/wb_sdr_arb_rr_pick.sv
// Rotating priority encoder: one-hot pick of the first requester strictly after
// `last` (wrapping at NM), plus a valid flag when any request is present.
module wb_sdr_arb_rr_pick #(
  parameter int NM = 4,
  parameter int LW = 2
) (
  input  logic [NM-1:0] req,
  input  logic [LW-1:0] last,
  output logic [NM-1:0] pick,
  output logic          valid
);

  // Walk the ring starting one past the previous owner; first hit wins.
  always_comb begin
    logic [LW-1:0] idx_s;
    logic          hit_s;
    pick  = '0;
    valid = 1'b0;
    idx_s = '0;
    hit_s = 1'b0;
    for (int i = 1; i <= NM; i++) begin
      idx_s       = LW'((int'(last) + i) % NM);
      hit_s       = ~valid & req[idx_s];
      pick[idx_s] = pick[idx_s] | hit_s;
      valid       = valid | hit_s;
    end
  end

endmodule

// File: rtl/wb_sdr_arb.sv
// Round-robin Wishbone arbiter sharing the sdrc_top slave port among NM masters.
// A grant spans a whole Wishbone cycle, including CTI incrementing bursts.
module wb_sdr_arb
  import wb_sdr_arb_pkg::*;
#(
  parameter int NM = 4,
  parameter int DW = 32,
  parameter int AW = 30
) (
  input  logic           wb_clk_i,
  input  logic           wb_resetn,
  wb_sdr_arb_if.slave    bus
);

  localparam int LW = (NM > 1) ? $clog2(NM) : 1;
  localparam int SW = DW / 8;

  arb_state_e     state_r;
  arb_state_e     state_nxt_s;
  logic [NM-1:0]  gnt_r;
  logic [NM-1:0]  gnt_nxt_s;
  logic [LW-1:0]  rr_last_r;
  logic [LW-1:0]  rr_last_nxt_s;
  logic [NM-1:0]  pick_s;
  logic           pick_valid_s;
  logic [LW-1:0]  own_idx_s;
  logic           grant_s;

  logic           own_cyc_s;
  logic           own_stb_s;
  logic           own_we_s;
  logic [AW-1:0]  own_addr_s;
  logic [DW-1:0]  own_dat_s;
  logic [SW-1:0]  own_sel_s;
  logic [2:0]     own_cti_s;

  wb_sdr_arb_rr_pick #(
    .NM (NM),
    .LW (LW)
  ) u_rr_pick (
    .req   (bus.m_cyc_i),
    .last  (rr_last_r),
    .pick  (pick_s),
    .valid (pick_valid_s)
  );

  assign own_idx_s = LW'(onehot_idx(8'(gnt_r)));
  assign grant_s   = (state_r == ARB_GRANT);

  // AND-OR mux of the owner's request signals; all zero while nobody is granted.
  always_comb begin
    own_cyc_s  = |(bus.m_cyc_i & gnt_r);
    own_stb_s  = |(bus.m_stb_i & gnt_r);
    own_we_s   = |(bus.m_we_i  & gnt_r);
    own_addr_s = '0;
    own_dat_s  = '0;
    own_sel_s  = '0;
    own_cti_s  = 3'b000;
    for (int k = 0; k < NM; k++) begin
      own_addr_s = own_addr_s | (bus.m_addr_i[k*AW +: AW] & {AW{gnt_r[k]}});
      own_dat_s  = own_dat_s  | (bus.m_dat_i[k*DW +: DW]  & {DW{gnt_r[k]}});
      own_sel_s  = own_sel_s  | (bus.m_sel_i[k*SW +: SW]  & {SW{gnt_r[k]}});
      own_cti_s  = own_cti_s  | (bus.m_cti_i[k*3 +: 3]    & {3{gnt_r[k]}});
    end
  end

  // Next-state logic; the grant is cleared on entry to RELEASE so the gap cycle shows no owner.
  always_comb begin
    state_nxt_s   = state_r;
    gnt_nxt_s     = gnt_r;
    rr_last_nxt_s = rr_last_r;
    case (state_r)
      ARB_IDLE: begin
        if (pick_valid_s) begin
          gnt_nxt_s   = pick_s;
          state_nxt_s = ARB_GRANT;
        end else begin
          gnt_nxt_s   = '0;
        end
      end
      ARB_GRANT: begin
        if (!own_cyc_s || (bus.s_ack_i && (own_cti_s == CTI_EOB))) begin
          rr_last_nxt_s = own_idx_s;
          gnt_nxt_s     = '0;
          state_nxt_s   = ARB_RELEASE;
        end else begin
          state_nxt_s   = ARB_GRANT;
        end
      end
      ARB_RELEASE: begin
        gnt_nxt_s   = '0;
        state_nxt_s = ARB_IDLE;
      end
      default: begin
        gnt_nxt_s   = '0;
        state_nxt_s = ARB_IDLE;
      end
    endcase
  end

  // State, owner and round-robin pointer; reset gives master 0 top priority.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_resetn) begin
      state_r   <= ARB_IDLE;
      gnt_r     <= '0;
      rr_last_r <= LW'(NM - 1);
    end else begin
      state_r   <= state_nxt_s;
      gnt_r     <= gnt_nxt_s;
      rr_last_r <= rr_last_nxt_s;
    end
  end

  assign bus.s_cyc_o  = grant_s & own_cyc_s;
  assign bus.s_stb_o  = grant_s & own_stb_s;
  assign bus.s_we_o   = grant_s & own_we_s;
  assign bus.s_addr_o = grant_s ? own_addr_s : '0;
  assign bus.s_dat_o  = grant_s ? own_dat_s  : '0;
  assign bus.s_sel_o  = grant_s ? own_sel_s  : '0;
  assign bus.s_cti_o  = grant_s ? own_cti_s  : 3'b000;

  // Ack only reaches the owner, even when it drops cyc in the ack cycle.
  assign bus.m_ack_o  = gnt_r & {NM{grant_s & bus.s_ack_i}};
  assign bus.m_dat_o  = bus.s_dat_i;
  assign bus.m_gnt_o  = gnt_r;

endmodule

// File: tb/tb_wb_sdr_arb.sv
// Directed bench for wb_sdr_arb: the bench plays all four masters and the sdrc_top
// slave port, with hand-computed grant order, ack routing and release timing.
module tb_wb_sdr_arb;
  import wb_sdr_arb_pkg::*;

  localparam int NM = 4;
  localparam int DW = 32;
  localparam int AW = 30;

  logic wb_clk_i  = 1'b0;
  logic wb_resetn = 1'b0;
  int   checks_cnt = 0;
  int   errors_cnt = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_sdr_arb_if #(.NM(NM), .DW(DW), .AW(AW)) bus ();

  wb_sdr_arb #(.NM(NM), .DW(DW), .AW(AW)) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_resetn (wb_resetn),
    .bus       (bus)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_master(input int k, input logic cyc, input logic we,
                            input logic [AW-1:0] addr, input logic [DW-1:0] dat,
                            input logic [2:0] cti);
    bus.m_cyc_i[k]              = cyc;
    bus.m_stb_i[k]              = cyc;
    bus.m_we_i[k]               = we;
    bus.m_addr_i[k*AW +: AW]    = addr;
    bus.m_dat_i[k*DW +: DW]     = dat;
    bus.m_sel_i[k*4 +: 4]       = cyc ? 4'hf : 4'h0;
    bus.m_cti_i[k*3 +: 3]       = cti;
  endtask

  task automatic clear_all();
    bus.m_cyc_i  = '0;
    bus.m_stb_i  = '0;
    bus.m_we_i   = '0;
    bus.m_addr_i = '0;
    bus.m_dat_i  = '0;
    bus.m_sel_i  = '0;
    bus.m_cti_i  = '0;
    bus.s_ack_i  = 1'b0;
    bus.s_dat_i  = '0;
  endtask

  // Bounded wait for any grant, then compare against the expected owner.
  task automatic wait_gnt(input string tag, input int k);
    logic [NM-1:0] exp_s;
    exp_s    = '0;
    exp_s[k] = 1'b1;
    for (int n = 0; n < 8 && bus.m_gnt_o == '0; n++) step();
    check_val(tag, 64'(bus.m_gnt_o), 64'(exp_s));
    check_val({tag, "_cyc"}, 64'(bus.s_cyc_o), 64'd1);
  endtask

  // One classic single-beat cycle for master k; ends one cycle into RELEASE.
  task automatic serve_classic(input string tag, input int k, input logic reraise);
    logic [NM-1:0] exp_s;
    exp_s    = '0;
    exp_s[k] = 1'b1;
    wait_gnt(tag, k);
    bus.s_ack_i = 1'b1;
    bus.s_dat_i = 32'hA000_0000 | 32'(k);
    settle();
    check_val({tag, "_ack"}, 64'(bus.m_ack_o), 64'(exp_s));
    check_val({tag, "_rdat"}, 64'(bus.m_dat_o), 64'(32'hA000_0000 | 32'(k)));
    step();
    check_val({tag, "_hold"}, 64'(bus.m_gnt_o), 64'(exp_s));
    bus.s_ack_i    = 1'b0;
    bus.m_cyc_i[k] = 1'b0;
    bus.m_stb_i[k] = 1'b0;
    settle();
    check_val({tag, "_drop"}, 64'(bus.s_cyc_o), 64'd0);
    step();
    check_val({tag, "_rel_gnt"}, 64'(bus.m_gnt_o), 64'd0);
    check_val({tag, "_rel_stb"}, 64'(bus.s_stb_o), 64'd0);
    if (reraise) begin
      bus.m_cyc_i[k] = 1'b1;
      bus.m_stb_i[k] = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state, with a stray slave ack that must not leak to any master.
    clear_all();
    bus.s_ack_i = 1'b1;
    bus.s_dat_i = 32'hDEAD_BEEF;
    wb_resetn   = 1'b0;
    step();
    step();
    check_val("rst_gnt", 64'(bus.m_gnt_o), 64'd0);
    check_val("rst_cyc", 64'(bus.s_cyc_o), 64'd0);
    check_val("rst_stb", 64'(bus.s_stb_o), 64'd0);
    check_val("rst_ack", 64'(bus.m_ack_o), 64'd0);
    check_val("rst_addr", 64'(bus.s_addr_o), 64'd0);
    check_val("rst_rdat", 64'(bus.m_dat_o), 64'h0000_0000_DEAD_BEEF);
    bus.s_ack_i = 1'b0;
    wb_resetn   = 1'b1;

    // 1: master 0 five-beat incrementing burst at 0x40000.
    set_master(0, 1'b1, 1'b1, 30'h0004_0000, 32'h0000_1000, CTI_INCR);
    settle();
    check_val("t1_idle_cyc", 64'(bus.s_cyc_o), 64'd0);
    step();
    check_val("t1_gnt", 64'(bus.m_gnt_o), 64'h1);
    check_val("t1_we", 64'(bus.s_we_o), 64'd1);
    for (int b = 0; b < 5; b++) begin
      set_master(0, 1'b1, 1'b1, 30'h0004_0000 + 30'(b), 32'h0000_1000 + 32'(b),
                 (b == 4) ? CTI_EOB : CTI_INCR);
      bus.s_ack_i = 1'b1;
      bus.s_dat_i = 32'h0000_5000 + 32'(b);
      settle();
      check_val("t1_addr", 64'(bus.s_addr_o), 64'(30'h0004_0000 + 30'(b)));
      check_val("t1_wdat", 64'(bus.s_dat_o), 64'(32'h0000_1000 + 32'(b)));
      check_val("t1_sel", 64'(bus.s_sel_o), 64'hf);
      check_val("t1_cti", 64'(bus.s_cti_o), (b == 4) ? 64'h7 : 64'h2);
      check_val("t1_ack", 64'(bus.m_ack_o), 64'h1);
      check_val("t1_rdat", 64'(bus.m_dat_o), 64'(32'h0000_5000 + 32'(b)));
      step();
    end
    bus.s_ack_i = 1'b0;
    settle();
    check_val("t1_rel_cyc", 64'(bus.s_cyc_o), 64'd0);
    check_val("t1_rel_gnt", 64'(bus.m_gnt_o), 64'd0);
    step();
    check_val("t1_idle2_cyc", 64'(bus.s_cyc_o), 64'd0);
    step();
    check_val("t1_regrant", 64'(bus.m_gnt_o), 64'h1);
    set_master(0, 1'b0, 1'b0, 30'h0, 32'h0, CTI_CLASSIC);
    step();
    step();

    // 2: all four request together straight out of reset.
    clear_all();
    wb_resetn = 1'b0;
    step();
    wb_resetn = 1'b1;
    for (int k = 0; k < NM; k++) set_master(k, 1'b1, 1'b0, 30'(k * 16), 32'h0, CTI_CLASSIC);
    serve_classic("t2_g0", 0, 1'b1);
    serve_classic("t2_g1", 1, 1'b1);
    serve_classic("t2_g2", 2, 1'b1);
    serve_classic("t2_g3", 3, 1'b1);
    serve_classic("t2_g4", 0, 1'b0);
    clear_all();

    // 3: masters 1 and 3 loop back-to-back.
    set_master(1, 1'b1, 1'b0, 30'h10, 32'h0, CTI_CLASSIC);
    set_master(3, 1'b1, 1'b0, 30'h30, 32'h0, CTI_CLASSIC);
    serve_classic("t3_a1", 1, 1'b1);
    serve_classic("t3_a3", 3, 1'b1);
    serve_classic("t3_b1", 1, 1'b1);
    serve_classic("t3_b3", 3, 1'b0);
    clear_all();
    step();

    // 4: master 2 burst while master 0 waits.
    set_master(2, 1'b1, 1'b1, 30'h100, 32'h0, CTI_INCR);
    wait_gnt("t4_g2", 2);
    set_master(0, 1'b1, 1'b0, 30'h200, 32'h0, CTI_CLASSIC);
    for (int b = 0; b < 5; b++) begin
      set_master(2, 1'b1, 1'b1, 30'h100 + 30'(b), 32'h0000_2000 + 32'(b),
                 (b == 4) ? CTI_EOB : CTI_INCR);
      bus.s_ack_i = 1'b1;
      settle();
      check_val("t4_gnt", 64'(bus.m_gnt_o), 64'h4);
      check_val("t4_ack", 64'(bus.m_ack_o), 64'h4);
      check_val("t4_addr", 64'(bus.s_addr_o), 64'(30'h100 + 30'(b)));
      step();
    end
    bus.s_ack_i = 1'b0;
    settle();
    check_val("t4_rel_gnt", 64'(bus.m_gnt_o), 64'd0);
    check_val("t4_rel_cyc", 64'(bus.s_cyc_o), 64'd0);
    set_master(2, 1'b0, 1'b0, 30'h0, 32'h0, CTI_CLASSIC);
    step();
    check_val("t4_idle_gnt", 64'(bus.m_gnt_o), 64'd0);
    step();
    check_val("t4_next_gnt", 64'(bus.m_gnt_o), 64'h1);
    serve_classic("t4_g0", 0, 1'b0);
    clear_all();

    // 5: master 1 drops cyc in its ack cycle; master 2 is next.
    set_master(1, 1'b1, 1'b0, 30'h11, 32'h0, CTI_CLASSIC);
    set_master(2, 1'b1, 1'b0, 30'h22, 32'h0, CTI_CLASSIC);
    wait_gnt("t5_g1", 1);
    bus.s_ack_i = 1'b1;
    set_master(1, 1'b0, 1'b0, 30'h0, 32'h0, CTI_CLASSIC);
    settle();
    check_val("t5_ack", 64'(bus.m_ack_o), 64'h2);
    step();
    check_val("t5_rel_ack", 64'(bus.m_ack_o), 64'd0);
    check_val("t5_rel_cyc", 64'(bus.s_cyc_o), 64'd0);
    check_val("t5_rel_gnt", 64'(bus.m_gnt_o), 64'd0);
    step();
    check_val("t5_idle_ack", 64'(bus.m_ack_o), 64'd0);
    bus.s_ack_i = 1'b0;
    serve_classic("t5_g2", 2, 1'b0);
    clear_all();

    // 6: reset in the middle of a master 3 burst.
    set_master(3, 1'b1, 1'b1, 30'h300, 32'h0, CTI_INCR);
    wait_gnt("t6_g3", 3);
    bus.s_ack_i = 1'b1;
    settle();
    check_val("t6_ack", 64'(bus.m_ack_o), 64'h8);
    step();
    step();
    for (int k = 0; k < 3; k++) set_master(k, 1'b1, 1'b0, 30'(k), 32'h0, CTI_CLASSIC);
    wb_resetn = 1'b0;
    step();
    check_val("t6_rst_cyc", 64'(bus.s_cyc_o), 64'd0);
    check_val("t6_rst_gnt", 64'(bus.m_gnt_o), 64'd0);
    check_val("t6_rst_ack", 64'(bus.m_ack_o), 64'd0);
    wb_resetn   = 1'b1;
    bus.s_ack_i = 1'b0;
    set_master(3, 1'b1, 1'b0, 30'h300, 32'h0, CTI_CLASSIC);
    serve_classic("t6_g0", 0, 1'b0);
    serve_classic("t6_g1", 1, 1'b0);
    clear_all();
    step();

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
